// File: rtl/interp_vec_seq.sv
// interp_vec_seq: multi-channel fixed-point linear interpolator (serial divide, one channel multiply per cycle)
module interp_vec_seq #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int CH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      Tk,
  input  logic [WIDTH-1:0]      Tn,
  input  logic [WIDTH-1:0]      Tz,
  input  logic [CH*WIDTH-1:0]   Un,
  input  logic [CH*WIDTH-1:0]   Uz,
  output logic [CH*WIDTH-1:0]   Uk,
  output logic                  busy,
  output logic                  ready,
  output logic                  err_ovf,
  output logic                  err_dz,
  output logic                  error
);
  localparam int D  = WIDTH + FRAC;
  localparam int CW = $clog2(D + CH + 1);
  localparam int PW = 2 * WIDTH + 2;
  localparam logic [D-1:0] HALF = D'(2 ** (WIDTH - 1));
  localparam logic signed [PW-1:0] SMAX = PW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SMIN = ~SMAX;
  typedef enum logic [2:0] {IDLE, SUB, DIV, MUL, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] tk_q, tn_q, tz_q, r_q, r_d;
  logic [CH*WIDTH-1:0] un_q, uz_q, uk_q, uk_d;
  logic ovf_q, ovf_d, dz_q, dz_d, neg_q, neg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] rem_q, rem_d, dvs_q, dvs_d, adk, adz;
  logic [D-1:0] num_q, num_d, qn;
  logic signed [WIDTH:0] dk, dz, dd;
  logic [WIDTH+1:0] trial, diff;
  logic ge, hi, lo, so_hi, so_lo;
  logic [WIDTH-1:0] rq, rn, un_c, uz_c, sat;
  logic signed [PW-1:0] rx, dx, ux, prod, s;
  assign dk    = {tk_q[WIDTH-1], tk_q} - {tn_q[WIDTH-1], tn_q};
  assign dz    = {tz_q[WIDTH-1], tz_q} - {tn_q[WIDTH-1], tn_q};
  assign adk   = dk[WIDTH] ? -dk : dk;
  assign adz   = dz[WIDTH] ? -dz : dz;
  assign trial = {rem_q, num_q[D-1]};
  assign ge    = trial >= {1'b0, dvs_q};
  assign diff  = trial - {1'b0, dvs_q};
  assign qn    = {num_q[D-2:0], ge};
  assign hi    = !neg_q && (qn >= HALF);
  assign lo    = neg_q && (qn > HALF);
  assign rq    = qn[WIDTH-1:0];
  assign rn    = hi ? {1'b0, {(WIDTH-1){1'b1}}} : lo ? {1'b1, {(WIDTH-1){1'b0}}} : neg_q ? -rq : rq;
  assign un_c  = un_q[cnt_q*WIDTH +: WIDTH];
  assign uz_c  = uz_q[cnt_q*WIDTH +: WIDTH];
  assign dd    = {uz_c[WIDTH-1], uz_c} - {un_c[WIDTH-1], un_c};
  assign rx    = {{(PW-WIDTH){r_q[WIDTH-1]}}, r_q};
  assign dx    = {{(PW-WIDTH-1){dd[WIDTH]}}, dd};
  assign ux    = {{(PW-WIDTH){un_c[WIDTH-1]}}, un_c};
  assign prod  = rx * dx;
  assign s     = (prod >>> FRAC) + ux;
  assign so_hi = s > SMAX;
  assign so_lo = s < SMIN;
  assign sat   = so_hi ? {1'b0, {(WIDTH-1){1'b1}}} : so_lo ? {1'b1, {(WIDTH-1){1'b0}}} : s[WIDTH-1:0];
  // next-state: job sequencing, divider step, per-channel multiply/saturate
  always_comb begin
    state_d = state_q;
    uk_d    = uk_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    num_d   = num_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    r_d     = r_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = start ? SUB : IDLE;
        uk_d    = start ? '0 : uk_q;
        ovf_d   = start ? 1'b0 : ovf_q;
        dz_d    = start ? 1'b0 : dz_q;
      end
      SUB: begin
        cnt_d   = '0;
        rem_d   = '0;
        num_d   = {adk[WIDTH-1:0], {FRAC{1'b0}}};
        dvs_d   = adz;
        neg_d   = dk[WIDTH] ^ dz[WIDTH];
        dz_d    = dz == '0;
        uk_d    = (dz == '0) ? un_q : uk_q;
        state_d = (dz == '0) ? DONE : DIV;
      end
      DIV: begin
        rem_d   = ge ? diff[WIDTH:0] : trial[WIDTH:0];
        num_d   = qn;
        cnt_d   = (cnt_q == CW'(D - 1)) ? '0 : cnt_q + 1'b1;
        r_d     = (cnt_q == CW'(D - 1)) ? rn : r_q;
        ovf_d   = ovf_q | ((cnt_q == CW'(D - 1)) && (hi || lo));
        state_d = (cnt_q == CW'(D - 1)) ? MUL : DIV;
      end
      MUL: begin
        uk_d[cnt_q*WIDTH +: WIDTH] = sat;
        ovf_d   = ovf_q | so_hi | so_lo;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(CH - 1)) ? DONE : MUL;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; inputs captured when a start is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      uk_q    <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      num_q   <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      r_q     <= '0;
      tk_q    <= '0;
      tn_q    <= '0;
      tz_q    <= '0;
      un_q    <= '0;
      uz_q    <= '0;
    end else begin
      state_q <= state_d;
      uk_q    <= uk_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      num_q   <= num_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      r_q     <= r_d;
      if ((state_q == IDLE || state_q == DONE) && start) begin
        tk_q <= Tk;
        tn_q <= Tn;
        tz_q <= Tz;
        un_q <= Un;
        uz_q <= Uz;
      end
    end
  end
  assign Uk      = uk_q;
  assign busy    = state_q == SUB || state_q == DIV || state_q == MUL;
  assign ready   = state_q == DONE;
  assign err_ovf = ovf_q;
  assign err_dz  = dz_q;
  assign error   = ovf_q | dz_q;
endmodule

// File: tb/tb_interp_vec_seq.sv
// tb_interp_vec_seq: vector table plus control sequences with a result scoreboard
module tb_interp_vec_seq;
  localparam int W = 16, F = 8, C = 2, L = W + F + C + 1;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0] Tk = '0, Tn = '0, Tz = '0;
  logic [C*W-1:0] Un = '0, Uz = '0, Uk;
  logic busy, ready, err_ovf, err_dz, error;
  int checks = 0, failures = 0;
  typedef struct {
    logic [W-1:0] tk, tn, tz;
    logic [C*W-1:0] un, uz, uk;
    logic ovf, dz;
    int lat;
  } vec_t;
  vec_t vecs[9];
  vec_t sb[$];
  vec_t last;

  interp_vec_seq #(.WIDTH(W), .FRAC(F), .CH(C)) dut (
    .clk(clk), .rst(rst), .start(start), .Tk(Tk), .Tn(Tn), .Tz(Tz),
    .Un(Un), .Uz(Uz), .Uk(Uk), .busy(busy), .ready(ready),
    .err_ovf(err_ovf), .err_dz(err_dz), .error(error)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [W-1:0] tk, tn, tz, input logic [C*W-1:0] un, uz, uk,
                              input logic ovf, dz);
    vec_t v;
    v.tk = tk; v.tn = tn; v.tz = tz; v.un = un; v.uz = uz; v.uk = uk;
    v.ovf = ovf; v.dz = dz; v.lat = dz ? 1 : L;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Tk = v.tk; Tn = v.tn; Tz = v.tz; Un = v.un; Uz = v.uz;
  endtask

  task automatic begin_job(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    start = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    chk({name, " busy"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_ready(input string name, input bit glitch, input vec_t alt);
    int lat = 0;
    vec_t e;
    while (ready !== 1'b1 && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (glitch) begin
        start = (lat == 4);
        if (lat == 4) drive(alt);
      end
    end
    e = sb.pop_front();
    last = e;
    chk({name, " latency"}, 64'(lat), 64'(e.lat));
    chk({name, " Uk"}, 64'(Uk), 64'(e.uk));
    chk({name, " err_ovf"}, 64'(err_ovf), 64'(e.ovf));
    chk({name, " err_dz"}, 64'(err_dz), 64'(e.dz));
    chk({name, " error"}, 64'(error), 64'(e.ovf | e.dz));
  endtask

  task automatic check_zero(input string name);
    chk({name, " Uk"}, 64'(Uk), 64'd0);
    chk({name, " flags"}, {59'd0, busy, ready, err_ovf, err_dz, error}, 64'd0);
  endtask

  initial begin
    vecs[0] = mk(16'h0100, 16'h0000, 16'h0200, {16'hFC00, 16'h0100}, {16'h0400, 16'h0300}, {16'h0000, 16'h0200}, 0, 0);
    vecs[1] = mk(16'h0400, 16'h0000, 16'h0200, {16'hFC00, 16'h0100}, {16'h0400, 16'h0300}, {16'h0C00, 16'h0500}, 0, 0);
    vecs[2] = mk(16'h0100, 16'h0000, 16'h0300, {16'h0000, 16'h0000}, {16'hFD00, 16'h0300}, {16'hFF01, 16'h00FF}, 0, 0);
    vecs[3] = mk(16'h7F00, 16'h0000, 16'h0001, {16'h0000, 16'h0000}, {16'hFF00, 16'h0100}, {16'h8001, 16'h7FFF}, 1, 0);
    vecs[4] = mk(16'h0000, 16'h0100, 16'h0100, {16'h8000, 16'h1234}, {16'h0000, 16'h0000}, {16'h8000, 16'h1234}, 0, 1);
    vecs[5] = mk(16'h0100, 16'h0200, 16'h0000, {16'h0000, 16'h0100}, {16'h0100, 16'h0300}, {16'h0080, 16'h0200}, 0, 0);
    vecs[6] = mk(16'hFF00, 16'h0000, 16'h0200, {16'h0000, 16'h0100}, {16'h0001, 16'h0300}, {16'hFFFF, 16'h0000}, 0, 0);
    vecs[7] = mk(16'h0200, 16'h0000, 16'h0100, {16'h8000, 16'h4000}, {16'h8100, 16'h7000}, {16'h8200, 16'h7FFF}, 1, 0);
    vecs[8] = mk(16'h8100, 16'h0000, 16'h0001, {16'h0000, 16'h0000}, {16'h0000, 16'h0100}, {16'h0000, 16'h8000}, 1, 0);
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      begin_job(vecs[i], $sformatf("vec%0d", i));
      start = 1'b0;
      wait_ready($sformatf("vec%0d", i), 1'b0, vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d ready pulse", i), 64'(ready), 64'd0);
      chk($sformatf("vec%0d hold Uk", i), 64'(Uk), 64'(last.uk));
    end
    rst = 1'b1;
    @(negedge clk);
    check_zero("reset idle");
    rst = 1'b0;
    begin_job(vecs[0], "glitch");
    start = 1'b0;
    wait_ready("glitch", 1'b1, vecs[1]);
    start = 1'b0;
    begin_job(vecs[3], "rst div");
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst div");
    rst = 1'b0;
    sb.delete();
    begin_job(vecs[2], "after rst");
    start = 1'b0;
    wait_ready("after rst", 1'b0, vecs[2]);
    begin_job(vecs[0], "b2b first");
    wait_ready("b2b first", 1'b0, vecs[0]);
    drive(vecs[1]);
    sb.push_back(vecs[1]);
    @(negedge clk);
    start = 1'b0;
    chk("b2b accepted busy", 64'(busy), 64'd1);
    wait_ready("b2b second", 1'b0, vecs[1]);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
